gpio_wb_arb: RTL and testbench

Two-master Wishbone-classic arbiter that shares the single 8-bit GPIO peripheral between the CPU data port (master 0) and the debug/DMA port (master 1). Sits between the bus decoder and the GPIO register block: fair round-robin selection, one outstanding transaction at a time, a mandatory idle cycle between grants, and a watchdog that terminates hung transactions with an error strobe.

---
 rtl/gpio_wb_arb_if.sv | 32 +++
 rtl/gpio_wb_arb.sv | 79 +++++++
 tb/tb_gpio_wb_arb.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_wb_arb_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the GPIO slave.
// The arbiter takes the slave modport; the environment drives the master modport.
interface gpio_wb_arb_if;
  logic [1:0] m0_addr, m1_addr;
  logic [7:0] m0_dat, m1_dat;
  logic       m0_we, m1_we;
  logic       m0_cyc, m1_cyc;
  logic [7:0] m0_rdt, m1_rdt;
  logic       m0_ack, m1_ack;
  logic       m0_err, m1_err;
  logic [1:0] s_addr;
  logic [7:0] s_dat;
  logic       s_we;
  logic       s_cyc;
  logic [7:0] s_rdt;
  logic       s_ack;
  logic [1:0] grant;

  modport slave (
    input  m0_addr, m1_addr, m0_dat, m1_dat, m0_we, m1_we, m0_cyc, m1_cyc,
    input  s_rdt, s_ack,
    output m0_rdt, m1_rdt, m0_ack, m1_ack, m0_err, m1_err,
    output s_addr, s_dat, s_we, s_cyc, grant
  );

  modport master (
    output m0_addr, m1_addr, m0_dat, m1_dat, m0_we, m1_we, m0_cyc, m1_cyc,
    output s_rdt, s_ack,
    input  m0_rdt, m1_rdt, m0_ack, m1_ack, m0_err, m1_err,
    input  s_addr, s_dat, s_we, s_cyc, grant
  );
endinterface

// File: rtl/gpio_wb_arb.sv
// Round-robin two-master Wishbone arbiter for the GPIO block; one transaction at a
// time, an idle cycle between grants, watchdog err after TIMEOUT busy cycles.
module gpio_wb_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rstn,
  gpio_wb_arb_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_owner;
  logic       r_last;
  logic [7:0] r_tcnt;

  logic w_busy;
  logic w_own_cyc;
  logic w_sel;
  logic w_ack;
  logic w_err;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_own_cyc = r_owner ? bus.m1_cyc : bus.m0_cyc;
  assign w_sel     = w_busy & w_own_cyc;
  // An owner abort suppresses both strobes; a slave ack masks the watchdog.
  assign w_ack     = w_sel & bus.s_ack;
  assign w_err     = w_sel & ~bus.s_ack & (r_tcnt == LP_TLAST);

  assign bus.s_cyc  = w_sel;
  assign bus.s_we   = w_sel & (r_owner ? bus.m1_we : bus.m0_we);
  assign bus.s_addr = w_sel ? (r_owner ? bus.m1_addr : bus.m0_addr) : 2'b00;
  assign bus.s_dat  = w_sel ? (r_owner ? bus.m1_dat : bus.m0_dat) : 8'h00;

  assign bus.m0_ack = w_ack & ~r_owner;
  assign bus.m1_ack = w_ack & r_owner;
  assign bus.m0_err = w_err & ~r_owner;
  assign bus.m1_err = w_err & r_owner;
  assign bus.m0_rdt = (w_busy & ~r_owner) ? bus.s_rdt : 8'h00;
  assign bus.m1_rdt = (w_busy & r_owner) ? bus.s_rdt : 8'h00;
  assign bus.grant  = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_tcnt  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= 8'h00;
          if (bus.m0_cyc && bus.m1_cyc) begin
            r_owner <= ~r_last;
            r_state <= ST_BUSY;
          end else if (bus.m0_cyc) begin
            r_owner <= 1'b0;
            r_state <= ST_BUSY;
          end else if (bus.m1_cyc) begin
            r_owner <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_own_cyc || bus.s_ack || (r_tcnt == LP_TLAST)) begin
            r_state <= ST_IDLE;
            r_last  <= r_owner;
          end else begin
            r_tcnt <= r_tcnt + 8'h01;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_wb_arb.sv
// Directed bench for gpio_wb_arb: per-cycle vector table plus timeout and reset sequences.
module tb_gpio_wb_arb;

  typedef struct packed {
    logic       rstn;
    logic       c0;
    logic       we0;
    logic [1:0] a0;
    logic [7:0] d0;
    logic       c1;
    logic       we1;
    logic [1:0] a1;
    logic [7:0] d1;
  } in_t;

  typedef struct packed {
    logic [1:0] grant;
    logic       s_cyc;
    logic       s_we;
    logic [7:0] s_dat;
    logic       ack0;
    logic       err0;
    logic       ack1;
    logic       err1;
    logic [7:0] rdt0;
    logic [7:0] rdt1;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  logic clk;
  logic rstn;
  logic ack_en;
  logic force_ack;
  int   n_run;
  int   n_fail;

  gpio_wb_arb_if bus ();

  gpio_wb_arb #(.TIMEOUT(15)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO register block model: registered ack one cycle after s_cyc, read data only with ack.
  logic [7:0] gpio [4];
  logic       slv_ack;
  logic [7:0] slv_rdt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slv_ack <= 1'b0;
      slv_rdt <= 8'h00;
      for (int i = 0; i < 4; i++) gpio[i] <= 8'h00;
    end else if (bus.s_cyc && !slv_ack && ack_en) begin
      slv_ack <= 1'b1;
      slv_rdt <= bus.s_we ? 8'h00 : gpio[bus.s_addr];
      if (bus.s_we) gpio[bus.s_addr] <= bus.s_dat;
    end else begin
      slv_ack <= 1'b0;
      slv_rdt <= 8'h00;
    end
  end

  assign bus.s_ack = slv_ack | force_ack;
  assign bus.s_rdt = slv_rdt;

  function automatic in_t mk_i(logic r, logic c0, logic w0, logic [1:0] a0, logic [7:0] d0,
                               logic c1, logic w1, logic [1:0] a1, logic [7:0] d1);
    in_t v;
    v = '{rstn: r, c0: c0, we0: w0, a0: a0, d0: d0, c1: c1, we1: w1, a1: a1, d1: d1};
    return v;
  endfunction

  function automatic exp_t mk_e(logic [1:0] g, logic sc, logic sw, logic [7:0] sd,
                                logic k0, logic e0, logic k1, logic e1,
                                logic [7:0] r0, logic [7:0] r1);
    exp_t v;
    v = '{grant: g, s_cyc: sc, s_we: sw, s_dat: sd, ack0: k0, err0: e0,
          ack1: k1, err1: e1, rdt0: r0, rdt1: r1};
    return v;
  endfunction

  task automatic apply(input in_t v);
    rstn        = v.rstn;
    bus.m0_cyc  = v.c0;
    bus.m0_we   = v.we0;
    bus.m0_addr = v.a0;
    bus.m0_dat  = v.d0;
    bus.m1_cyc  = v.c1;
    bus.m1_we   = v.we1;
    bus.m1_addr = v.a1;
    bus.m1_dat  = v.d1;
  endtask

  task automatic check(input string name, input exp_t e);
    exp_t act;
    act = '{grant: bus.grant, s_cyc: bus.s_cyc, s_we: bus.s_we, s_dat: bus.s_dat,
            ack0: bus.m0_ack, err0: bus.m0_err, ack1: bus.m1_ack, err1: bus.m1_err,
            rdt0: bus.m0_rdt, rdt1: bus.m1_rdt};
    n_run++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got {grant,s_cyc,s_we,s_dat,ack0,err0,ack1,err1,rdt0,rdt1}=%h expected %h",
               name, act, e);
    end
  endtask

  // One clock cycle: drive just after the edge, compare mid-cycle.
  task automatic cycle(input string name, input in_t v, input exp_t e);
    @(posedge clk);
    #1 apply(v);
    #3 check(name, e);
  endtask

  vec_t tbl [37];

  initial begin
    exp_t e0;
    in_t  iz;
    in_t  ia;
    in_t  ib;
    n_run     = 0;
    n_fail    = 0;
    ack_en    = 1'b1;
    force_ack = 1'b0;
    e0 = mk_e(2'b00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00);
    iz = mk_i(1, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00);
    apply(mk_i(0, 0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00));

    // Reset held with both requests, then master 0 wins the first tie.
    tbl[0]  = '{mk_i(0, 1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00), e0};
    tbl[1]  = '{mk_i(0, 1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00), e0};
    tbl[2]  = '{mk_i(1, 1, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00), e0};
    tbl[3]  = '{mk_i(1, 1, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[4]  = '{mk_i(1, 1, 0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00)};
    tbl[5]  = '{iz, e0};
    // m0 writes A5 to reg 2, then reads it back.
    tbl[6]  = '{mk_i(1, 1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00), e0};
    tbl[7]  = '{mk_i(1, 1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 1, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[8]  = '{mk_i(1, 1, 1, 2'd2, 8'hA5, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 1, 8'hA5, 1, 0, 0, 0, 8'h00, 8'h00)};
    tbl[9]  = '{iz, e0};
    tbl[10] = '{mk_i(1, 1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00), e0};
    tbl[11] = '{mk_i(1, 1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[12] = '{mk_i(1, 1, 0, 2'd2, 8'h00, 0, 0, 2'd0, 8'h00), mk_e(2'b01, 1, 0, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00)};
    tbl[13] = '{iz, e0};
    // m1 writes 3C to reg 1, leaving last = 1.
    tbl[14] = '{mk_i(1, 0, 0, 2'd0, 8'h00, 1, 1, 2'd1, 8'h3C), e0};
    tbl[15] = '{mk_i(1, 0, 0, 2'd0, 8'h00, 1, 1, 2'd1, 8'h3C), mk_e(2'b10, 1, 1, 8'h3C, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[16] = '{mk_i(1, 0, 0, 2'd0, 8'h00, 1, 1, 2'd1, 8'h3C), mk_e(2'b10, 1, 1, 8'h3C, 0, 0, 1, 0, 8'h00, 8'h00)};
    tbl[17] = '{iz, e0};
    // Continuous contention: four alternating reads with an idle cycle between grants.
    ia = mk_i(1, 1, 0, 2'd2, 8'h00, 1, 0, 2'd1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      tbl[18 + 6*k] = '{ia, e0};
      tbl[19 + 6*k] = '{ia, mk_e(2'b01, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
      tbl[20 + 6*k] = '{ia, mk_e(2'b01, 1, 0, 8'h00, 1, 0, 0, 0, 8'hA5, 8'h00)};
      tbl[21 + 6*k] = '{ia, e0};
      tbl[22 + 6*k] = '{ia, mk_e(2'b10, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
      tbl[23 + 6*k] = '{ia, mk_e(2'b10, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h3C)};
    end
    tbl[30] = '{iz, e0};
    // m0 aborts a write of FF to reg 1 while m1 waits; m1 then reads reg 1 unchanged.
    ib = mk_i(1, 0, 1, 2'd1, 8'hFF, 1, 0, 2'd1, 8'h00);
    tbl[31] = '{mk_i(1, 1, 1, 2'd1, 8'hFF, 1, 0, 2'd1, 8'h00), e0};
    tbl[32] = '{ib, mk_e(2'b01, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[33] = '{ib, e0};
    tbl[34] = '{ib, mk_e(2'b10, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[35] = '{ib, mk_e(2'b10, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h3C)};
    tbl[36] = '{iz, e0};

    @(posedge clk);
    for (int i = 0; i < 37; i++) cycle($sformatf("vec%0d", i), tbl[i].in, tbl[i].ex);

    // Watchdog: slave silent, err on the 15th busy cycle only.
    ack_en = 1'b0;
    ia = mk_i(1, 0, 0, 2'd0, 8'h00, 1, 0, 2'd0, 8'h00);
    cycle("to_req", ia, e0);
    for (int k = 1; k <= 15; k++)
      cycle($sformatf("to_busy%0d", k), ia,
            mk_e(2'b10, 1, 0, 8'h00, 0, 0, 0, (k == 15), 8'h00, 8'h00));
    cycle("to_idle", iz, e0);

    // Ack arriving in the watchdog cycle wins over err.
    cycle("ta_req", ia, e0);
    for (int k = 1; k <= 14; k++)
      cycle($sformatf("ta_busy%0d", k), ia, mk_e(2'b10, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    @(posedge clk);
    #1 apply(ia);
    force_ack = 1'b1;
    #3 check("ta_busy15", mk_e(2'b10, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00));
    @(posedge clk);
    #1 apply(iz);
    force_ack = 1'b0;
    #3 check("ta_idle", e0);
    ack_en = 1'b1;

    // Reset while BUSY: cycle drops, no strobe, next tie goes to master 0.
    ia = mk_i(1, 1, 1, 2'd3, 8'h77, 0, 0, 2'd0, 8'h00);
    cycle("rst_req", ia, e0);
    cycle("rst_busy", mk_i(0, 1, 1, 2'd3, 8'h77, 0, 0, 2'd0, 8'h00),
          mk_e(2'b01, 1, 1, 8'h77, 0, 0, 0, 0, 8'h00, 8'h00));
    cycle("rst_drop", mk_i(0, 1, 1, 2'd3, 8'h77, 1, 0, 2'd0, 8'h00), e0);
    cycle("rst_rel", mk_i(1, 1, 1, 2'd3, 8'h77, 1, 0, 2'd0, 8'h00), e0);
    cycle("rst_tie", mk_i(1, 1, 1, 2'd3, 8'h77, 1, 0, 2'd0, 8'h00),
          mk_e(2'b01, 1, 1, 8'h77, 0, 0, 0, 0, 8'h00, 8'h00));
    cycle("rst_abort", iz, mk_e(2'b01, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
    cycle("rst_end", iz, e0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "bench time limit");
  end

endmodule
